bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3: number of requesting masters, range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles one grant may be held, range 2..65535.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 Port m_req, input, NUM_MASTERS: per-master bus request, level, held for the whole transaction.
REQ-006 Port slave_busy, input, 1: resolved wired slave-busy line; 1 = some slave still active.
REQ-007 Port m_grant, output, NUM_MASTERS: one-hot grant, registered.
REQ-008 Port grant_id, output, clog2(NUM_MASTERS): index of the current or last owner, registered.
REQ-009 Port bus_util, output, 1: bus-in-use indication to all slaves, registered.
REQ-010 Port timeout_err, output, 1: one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-011 The FSM states SHALL be IDLE, GRANT and RELEASE.
REQ-012 IDLE: m_grant=0, bus_util=0, and slave_busy is ignored.
REQ-013 IDLE with eligible request: on that edge, assert m_grant[w] and bus_util=1, load grant_id=w, clear the watchdog, and move to GRANT; grant is visible one cycle after the request is sampled.
REQ-014 The eligible set SHALL be m_req AND NOT timeout_mask.
REQ-015 GRANT: hold m_grant, bus_util=1, and increment the watchdog by 1 per cycle while m_req[owner]=1.
REQ-016 GRANT with m_req[owner]=0: clear m_grant on that edge, keep bus_util=1, and move to RELEASE.
REQ-017 GRANT with watchdog=TIMEOUT_CYCLES-1 and m_req[owner] still 1: clear m_grant, pulse timeout_err for 1 cycle, set timeout_mask[owner], and move to RELEASE.
REQ-018 When release and timeout coincide in the same cycle, release wins and no timeout_err is raised.
REQ-019 RELEASE: m_grant=0, bus_util=1; when slave_busy=0 is sampled, clear bus_util and move to IDLE, giving a minimum 1 cycle of bus_util=0 between owners.
REQ-020 RELEASE with slave_busy stuck at 1 SHALL remain in RELEASE indefinitely (no watchdog in RELEASE).
REQ-021 Requests raised or dropped during GRANT or RELEASE by non-owners SHALL have no effect until IDLE.
REQ-022 timeout_mask[i] SHALL clear on any edge where m_req[i]=0, in any state.
REQ-023 m_grant SHALL never have more than one bit set; bus_util SHALL be 1 whenever m_grant is non-zero.
REQ-024 The watchdog SHALL be a 16-bit counter, saturating, and never wraps.
REQ-025 grant_id SHALL retain the last owner in IDLE and RELEASE.

Reset
REQ-026 With rstn=0, immediately and independent of clk: state=IDLE, m_grant=0, bus_util=0, timeout_err=0, grant_id=0, watchdog=0, timeout_mask=0, last_owner=NUM_MASTERS-1.
REQ-027 Reset asserted mid-GRANT or mid-RELEASE SHALL abort the transaction with no timeout_err pulse; first grant after reset follows REQ-013 from IDLE.

Configuration
REQ-028 The macro ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-029 With ARB_ROUND_ROBIN_EN defined: winner is the first eligible index searching upward from (last_owner+1) mod NUM_MASTERS; last_owner updates to the winner at each grant.
REQ-030 Without ARB_ROUND_ROBIN_EN: fixed priority, with the lowest eligible index winning; last_owner is unused.

Verification
REQ-031 Scenario: single request. m_req=001 in IDLE -> next cycle m_grant=001, bus_util=1; drop req with slave_busy=0 -> RELEASE 1 cycle, then bus_util=0.
REQ-032 Scenario: contention. m_req=111 held, each owner drops after 5 cycles then re-requests. With ARB_ROUND_ROBIN_EN -> grant order 0,1,2,0. Without it -> 0,0,0.
REQ-033 Scenario: watchdog. TIMEOUT_CYCLES=8 and master 1 holds req -> after 8 GRANT cycles m_grant=000 and timeout_err=1 for one cycle; master 1 is not regranted until its req drops for one cycle.
REQ-034 Scenario: slave hold-off. Owner drops req with slave_busy=1 for 10 cycles -> bus_util stays 1 for those 10 cycles and falls the cycle after slave_busy=0; no grant occurs meanwhile despite m_req=110.
REQ-035 Scenario: async reset. rstn pulsed low mid-GRANT between clock edges -> m_grant=0 and bus_util=0 immediately; after release, m_req=100 yields grant to master 2 one cycle later.
REQ-036 Scenario: coincidence. Owner drops req exactly at watchdog=TIMEOUT_CYCLES-1 -> no timeout_err, and the owner's timeout_mask bit stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: single-clock arbiter granting one of NUM_MASTERS masters at a time.
// The FSM walks IDLE -> GRANT -> RELEASE -> IDLE. A per-grant watchdog revokes a
// grant held for TIMEOUT_CYCLES cycles and masks that master until its request drops.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration. When it
// is undefined, arbitration is fixed priority and the lowest eligible index wins.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         m_req,
    input  logic                           slave_busy,
    output logic [NUM_MASTERS-1:0]         m_grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           bus_util,
    output logic                           timeout_err
);

    localparam int IDW = $clog2(NUM_MASTERS);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] WD_MAX  = 16'hFFFF;
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] m_grant_q, m_grant_d;
    logic [IDW-1:0]         grant_id_q, grant_id_d;
    logic                   bus_util_q, bus_util_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [15:0]            wd_q, wd_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;

    logic [NUM_MASTERS-1:0] eligible_s;
    logic                   win_valid_s;
    logic [IDW-1:0]         win_idx_s;
    logic                   owner_req_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]         last_owner_q, last_owner_d;
    int                     cand_s;

    // Round-robin winner: first eligible index searching upward from last_owner+1.
    always_comb begin
        eligible_s  = m_req & ~mask_q;
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand_s = int'(last_owner_q) + 1 + k;
            cand_s = (cand_s >= NUM_MASTERS) ? (cand_s - NUM_MASTERS) : cand_s;
            win_idx_s   = (!win_valid_s && eligible_s[cand_s]) ? IDW'(cand_s) : win_idx_s;
            win_valid_s = win_valid_s | eligible_s[cand_s];
        end
    end
`else
    // Fixed-priority winner: lowest eligible index.
    always_comb begin
        eligible_s  = m_req & ~mask_q;
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            win_idx_s   = (!win_valid_s && eligible_s[k]) ? IDW'(k) : win_idx_s;
            win_valid_s = win_valid_s | eligible_s[k];
        end
    end
`endif

    // Next-state and next-output logic for the grant FSM, watchdog and timeout mask.
    always_comb begin
        state_d       = state_q;
        m_grant_d     = m_grant_q;
        grant_id_d    = grant_id_q;
        bus_util_d    = bus_util_q;
        timeout_err_d = 1'b0;
        wd_d          = wd_q;
        // A master's timeout mask clears on any cycle its request is low.
        mask_d        = mask_q & m_req;
        owner_req_s   = m_req[grant_id_q];
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d  = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                m_grant_d  = '0;
                bus_util_d = 1'b0;
                if (win_valid_s) begin
                    m_grant_d  = ONE_HOT0 << win_idx_s;
                    bus_util_d = 1'b1;
                    grant_id_d = win_idx_s;
                    wd_d       = 16'd0;
                    state_d    = GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = win_idx_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                bus_util_d = 1'b1;
                if (!owner_req_s) begin
                    // Voluntary release takes precedence over a coincident timeout.
                    m_grant_d = '0;
                    state_d   = RELEASE;
                end else if (wd_q == WD_LAST) begin
                    m_grant_d     = '0;
                    timeout_err_d = 1'b1;
                    mask_d        = mask_d | (ONE_HOT0 << grant_id_q);
                    state_d       = RELEASE;
                end else begin
                    wd_d = (wd_q == WD_MAX) ? wd_q : (wd_q + 16'd1);
                end
            end
            RELEASE: begin
                m_grant_d = '0;
                if (!slave_busy) begin
                    bus_util_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    bus_util_d = 1'b1;
                end
            end
            default: begin
                m_grant_d  = '0;
                bus_util_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered-output flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            m_grant_q     <= '0;
            grant_id_q    <= '0;
            bus_util_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_q          <= 16'd0;
            mask_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q  <= IDW'(NUM_MASTERS - 1);
`endif
        end else begin
            state_q       <= state_d;
            m_grant_q     <= m_grant_d;
            grant_id_q    <= grant_id_d;
            bus_util_q    <= bus_util_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
            mask_q        <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q  <= last_owner_d;
`endif
        end
    end

    assign m_grant     = m_grant_q;
    assign grant_id    = grant_id_q;
    assign bus_util    = bus_util_q;
    assign timeout_err = timeout_err_q;

endmodule
